eclk_bus_sync: RTL
==================

ECLK_BUS_SYNC -- requirements
Module: eclk_bus_sync

Interface
REQ-001 SHALL have parameter LATE_PHASE, default 2, meaning the last E phase index at which a new request still joins the current E period.
REQ-002 SHALL have port clk  input  1  system clock (7.09 MHz domain); the only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port eclk  input  10  one-hot E-period phase enables; bit k is high for the clk cycle of phase k.
REQ-005 SHALL have port sel  input  1  CPU peripheral (6800-style) access request, level, held until dtack.
REQ-006 SHALL have port rnw  input  1  CPU read-not-write, valid while sel is high.
REQ-007 SHALL have port e  output  1  registered E clock level to peripherals.
REQ-008 SHALL have port vma  output  1  registered valid-memory-address to peripherals.
REQ-009 SHALL have port we  output  1  registered write enable, valid while vma is high.
REQ-010 SHALL have port cia_en  output  1  one-cycle register-action strobe to peripherals.
REQ-011 SHALL have port dtack  output  1  one-cycle completion pulse to CPU.
REQ-012 SHALL have port busy  output  1  high whenever FSM is not IDLE (state decode).

Function
REQ-013 SHALL decode phase as index of lowest set eclk bit; all-zero eclk = no phase event, FSM and e hold.
REQ-014 SHALL set e to 1 on the edge where eclk[5] is high and to 0 on the edge where eclk[9] is high; e high 4 cycles, low 6 per period.
REQ-015 SHALL implement states IDLE, WAIT, ACCESS, RELEASE.
REQ-016 IDLE: sel high with phase k <= LATE_PHASE -> ACCESS; vma<=1, we<=~rnw on the same edge.
REQ-017 IDLE: sel high with phase k > LATE_PHASE, or with no phase event -> WAIT.
REQ-018 WAIT: sel low -> IDLE, no outputs asserted (abort).
REQ-019 WAIT: sel high and eclk[0] high -> ACCESS; vma<=1, we<=~rnw.
REQ-020 ACCESS: on eclk[9] -> RELEASE; vma<=0, we<=0, cia_en<=1, dtack<=1 for exactly one cycle.
REQ-021 ACCESS SHALL ignore sel and rnw changes; a started access always completes with cia_en and dtack.
REQ-022 RELEASE: sel low -> IDLE; sel high -> stay, no further dtack (back-to-back requests need sel low >= 1 cycle).
REQ-023 cia_en and dtack SHALL never be high except the cycle after an ACCESS eclk[9] edge.
REQ-024 Latency sel-in-IDLE at phase k<=LATE_PHASE to dtack high SHALL be 10-k cycles.
REQ-025 Multiple eclk bits set SHALL be treated per REQ-013 (lowest index wins); no error state.

Reset
REQ-026 reset high on an edge SHALL force state IDLE and e, vma, we, cia_en, dtack to 0; busy 0 next cycle.
REQ-027 reset mid-ACCESS SHALL abort with no cia_en/dtack pulse; reset priority over all transitions.

Verification
REQ-028 Reset, rotate eclk 0..9 repeatedly, sel low -> e high exactly cycles after phases 5..8 edges through phase 9 edge (4 of 10), vma/cia_en/dtack stay 0.
REQ-029 sel=1, rnw=0 sampled at phase 1 -> vma=1, we=1 from next cycle; cia_en=dtack=1 one cycle after phase-9 edge (9 cycles); vma=0 same cycle.
REQ-030 sel=1 sampled at phase 4 -> WAIT, busy=1, vma=0; vma=1 after next phase-0 edge; dtack 16 cycles after sel.
REQ-031 sel=1 at phase 6 then sel=0 at phase 8 -> WAIT then IDLE; vma, cia_en, dtack never asserted.
REQ-032 reset pulsed during ACCESS at phase 5 -> next cycle all outputs 0, state IDLE; no cia_en at following phase 9.
REQ-033 eclk held 0 for 20 cycles during WAIT with sel=1 -> state, e, vma unchanged; resumes at next eclk[0].

Source files
------------

// File: rtl/eclk_bus_sync.sv
// Purpose: synchronises 6800-style CPU peripheral accesses to a 10-phase E period and generates E, VMA, WE, CIA_EN and DTACK.
// Latency: a request seen in IDLE at phase k <= LATE_PHASE completes with dtack 10-k cycles later; later requests wait for the next phase 0.
// Backpressure: the CPU holds sel until dtack; sel must drop for at least one cycle before the next request is accepted.
module eclk_bus_sync #(
    parameter int LATE_PHASE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] eclk,
    input  logic       sel,
    input  logic       rnw,
    output logic       e,
    output logic       vma,
    output logic       we,
    output logic       cia_en,
    output logic       dtack,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] LATE = 4'(LATE_PHASE);

    state_t     state;
    state_t     state_nxt;
    logic       vma_nxt;
    logic       we_nxt;
    logic       strobe;
    logic       strobe_nxt;
    logic [3:0] phase;
    logic       phase_vld;
    logic       ph0;
    logic       ph5;
    logic       ph9;
    logic       early;

    // Phase decode: the lowest set eclk bit wins, so malformed multi-hot inputs never need an error path.
    always_comb begin
        phase     = 4'd0;
        phase_vld = |eclk;
        for (int i = 9; i >= 0; i--) begin
            if (eclk[i]) begin
                phase = 4'(i);
            end
        end
    end

    assign ph0   = phase_vld && (phase == 4'd0);
    assign ph5   = phase_vld && (phase == 4'd5);
    assign ph9   = phase_vld && (phase == 4'd9);
    assign early = phase_vld && (phase <= LATE);

    // Next-state and next-output logic; an access, once started, ignores sel/rnw until its phase-9 completion.
    always_comb begin
        state_nxt  = state;
        vma_nxt    = vma;
        we_nxt     = we;
        strobe_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel) begin
                    if (early) begin
                        state_nxt = ST_ACCESS;
                        vma_nxt   = 1'b1;
                        we_nxt    = ~rnw;
                    end else begin
                        state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!sel) begin
                    state_nxt = ST_IDLE;
                end else if (ph0) begin
                    state_nxt = ST_ACCESS;
                    vma_nxt   = 1'b1;
                    we_nxt    = ~rnw;
                end
            end
            ST_ACCESS: begin
                if (ph9) begin
                    state_nxt  = ST_RELEASE;
                    vma_nxt    = 1'b0;
                    we_nxt     = 1'b0;
                    strobe_nxt = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!sel) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                vma_nxt   = 1'b0;
                we_nxt    = 1'b0;
            end
        endcase
    end

    // State and bus output registers; reset overrides every transition, including a pending completion strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            vma    <= 1'b0;
            we     <= 1'b0;
            strobe <= 1'b0;
        end else begin
            state  <= state_nxt;
            vma    <= vma_nxt;
            we     <= we_nxt;
            strobe <= strobe_nxt;
        end
    end

    // E clock: rises on the phase-5 edge and falls on the phase-9 edge, giving 4 high / 6 low per period.
    always_ff @(posedge clk) begin
        if (reset) begin
            e <= 1'b0;
        end else if (ph5) begin
            e <= 1'b1;
        end else if (ph9) begin
            e <= 1'b0;
        end
    end

    assign cia_en = strobe;
    assign dtack  = strobe;
    assign busy   = (state != ST_IDLE);

endmodule
